// File: rtl/ggt_param_core.sv
// GCD engine (subtractive Euclid or binary Stein by MODE) with abort and saturating RUN-cycle count.
// Result and valid appear n RUN cycles after an accepted start; start is only taken while ready_o=1.
module ggt_param_core #(
  parameter int WIDTH = 16,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] Zahl1_i,
  input  logic [WIDTH-1:0] Zahl2_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] ergebnis,
  output logic             valid,
  output logic [CNT_W-1:0] zyklen_o
);

  localparam int KW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] zyk_q, zyk_d;
  logic             valid_q, valid_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             step_fin;
  logic [WIDTH-1:0] step_res;
  logic [WIDTH-1:0] a_nx, b_nx;
  logic [KW-1:0]    k_nx;

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

  // k stays 0 in Euclid mode, so the shifted result form serves both algorithms.
  always_comb begin
    step_fin = 1'b0;
    step_res = '0;
    a_nx     = a_q;
    b_nx     = b_q;
    k_nx     = k_q;
    if (a_q == '0) begin
      step_fin = 1'b1;
      step_res = b_q << k_q;
    end else if ((b_q == '0) || (a_q == b_q)) begin
      step_fin = 1'b1;
      step_res = a_q << k_q;
    end else if (MODE == 0) begin
      if (a_q > b_q) a_nx = a_q - b_q;
      else           b_nx = b_q - a_q;
    end else begin
      if (!a_q[0] && !b_q[0]) begin
        a_nx = a_q >> 1;
        b_nx = b_q >> 1;
        k_nx = k_q + KW'(1);
      end else if (!a_q[0]) begin
        a_nx = a_q >> 1;
      end else if (!b_q[0]) begin
        b_nx = b_q >> 1;
      end else if (a_q > b_q) begin
        a_nx = (a_q - b_q) >> 1;
      end else begin
        b_nx = (b_q - a_q) >> 1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    zyk_d   = zyk_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (start_i) begin
          a_d     = Zahl1_i;
          b_d     = Zahl2_i;
          k_d     = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
          a_d   = a_nx;
          b_d   = b_nx;
          k_d   = k_nx;
          if (step_fin) begin
            res_d   = step_res;
            zyk_d   = cnt_inc;
            valid_d = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      zyk_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      zyk_q   <= zyk_d;
      valid_q <= valid_d;
    end
  end

  assign ready_o  = (state_q != ST_RUN);
  assign ergebnis = res_q;
  assign valid    = valid_q;
  assign zyklen_o = zyk_q;

endmodule

// File: tb/tb_ggt_param_core.sv
// Five engine variants share one stimulus stream; a job-level model (result, cycle count,
// handshake) predicts every output each cycle.
module tb_ggt_param_core;

  localparam int NI = 5;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        abort_i;
  logic [15:0] Zahl1_i;
  logic [15:0] Zahl2_i;

  logic [NI-1:0] rdy, vld;
  logic [15:0]   r0, r1, r2, z0, z1, z3, z4;
  logic [7:0]    r3, r4, z2;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Variants: 0 Euclid/16, 1 Stein/16, 2 Euclid/16 with 8-bit counter, 3 Euclid/8, 4 Stein/8.
  ggt_param_core #(.WIDTH(16), .MODE(0), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .start_i(start_i),
    .abort_i(abort_i), .Zahl1_i(Zahl1_i), .Zahl2_i(Zahl2_i), .ready_o(rdy[0]), .ergebnis(r0),
    .valid(vld[0]), .zyklen_o(z0));
  ggt_param_core #(.WIDTH(16), .MODE(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .start_i(start_i),
    .abort_i(abort_i), .Zahl1_i(Zahl1_i), .Zahl2_i(Zahl2_i), .ready_o(rdy[1]), .ergebnis(r1),
    .valid(vld[1]), .zyklen_o(z1));
  ggt_param_core #(.WIDTH(16), .MODE(0), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .start_i(start_i),
    .abort_i(abort_i), .Zahl1_i(Zahl1_i), .Zahl2_i(Zahl2_i), .ready_o(rdy[2]), .ergebnis(r2),
    .valid(vld[2]), .zyklen_o(z2));
  ggt_param_core #(.WIDTH(8), .MODE(0), .CNT_W(16)) u3 (.clk(clk), .rst(rst), .start_i(start_i),
    .abort_i(abort_i), .Zahl1_i(Zahl1_i[7:0]), .Zahl2_i(Zahl2_i[7:0]), .ready_o(rdy[3]),
    .ergebnis(r3), .valid(vld[3]), .zyklen_o(z3));
  ggt_param_core #(.WIDTH(8), .MODE(1), .CNT_W(16)) u4 (.clk(clk), .rst(rst), .start_i(start_i),
    .abort_i(abort_i), .Zahl1_i(Zahl1_i[7:0]), .Zahl2_i(Zahl2_i[7:0]), .ready_o(rdy[4]),
    .ergebnis(r4), .valid(vld[4]), .zyklen_o(z4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int inst_mode(input int i);
    return (i == 1 || i == 4) ? 1 : 0;
  endfunction

  function automatic logic [63:0] inst_mask(input int i);
    return (i >= 3) ? 64'hFF : 64'hFFFF;
  endfunction

  function automatic logic [63:0] inst_sat(input int i);
    return (i == 2) ? 64'hFF : 64'hFFFF;
  endfunction

  function automatic logic [63:0] gcd_ref(input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] a, b, t;
    a = a_in;
    b = b_in;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of RUN cycles the algorithm's rules need, including the terminating one.
  function automatic int steps_ref(input int mode, input logic [63:0] a_in, input logic [63:0] b_in);
    logic [63:0] a, b;
    int n;
    a = a_in;
    b = b_in;
    n = 0;
    while (n < 200000) begin
      n++;
      if (a == 0 || b == 0 || a == b) return n;
      if (mode == 0) begin
        if (a > b) a = a - b;
        else       b = b - a;
      end else if (a[0] == 1'b0 && b[0] == 1'b0) begin
        a = a >> 1;
        b = b >> 1;
      end else if (a[0] == 1'b0) begin
        a = a >> 1;
      end else if (b[0] == 1'b0) begin
        b = b >> 1;
      end else if (a > b) begin
        a = (a - b) >> 1;
      end else begin
        b = (b - a) >> 1;
      end
    end
    return n;
  endfunction

  int          m_rem  [NI];
  bit          m_vld  [NI];
  logic [63:0] m_res  [NI];
  logic [63:0] m_zyk  [NI];
  logic [63:0] m_pres [NI];
  logic [63:0] m_pn   [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_rem[i] <= 0;
        m_vld[i] <= 1'b0;
        m_res[i] <= '0;
        m_zyk[i] <= '0;
      end else if (m_rem[i] > 0) begin
        if (abort_i) begin
          m_rem[i] <= 0;
        end else begin
          m_rem[i] <= m_rem[i] - 1;
          if (m_rem[i] == 1) begin
            m_vld[i] <= 1'b1;
            m_res[i] <= m_pres[i];
            m_zyk[i] <= (m_pn[i] > inst_sat(i)) ? inst_sat(i) : m_pn[i];
          end
        end
      end else if (abort_i) begin
        m_vld[i] <= 1'b0;
      end else if (start_i) begin
        m_rem[i]  <= steps_ref(inst_mode(i), {48'h0, Zahl1_i} & inst_mask(i), {48'h0, Zahl2_i} & inst_mask(i));
        m_pn[i]   <= 64'(steps_ref(inst_mode(i), {48'h0, Zahl1_i} & inst_mask(i), {48'h0, Zahl2_i} & inst_mask(i)));
        m_pres[i] <= gcd_ref({48'h0, Zahl1_i} & inst_mask(i), {48'h0, Zahl2_i} & inst_mask(i));
        m_vld[i]  <= 1'b0;
      end
    end
  end

  function automatic logic [33:0] got_vec(input int i);
    case (i)
      0:       return {rdy[0], vld[0], r0, z0};
      1:       return {rdy[1], vld[1], r1, z1};
      2:       return {rdy[2], vld[2], r2, 8'h00, z2};
      3:       return {rdy[3], vld[3], 8'h00, r3, z3};
      default: return {rdy[4], vld[4], 8'h00, r4, z4};
    endcase
  endfunction

  function automatic logic [33:0] exp_vec(input int i);
    return {(m_rem[i] == 0), m_vld[i], m_res[i][15:0], m_zyk[i][15:0]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        n_cmp++;
        if (got_vec(i) !== exp_vec(i)) begin
          n_err++;
          $display("FAIL outputs u%0d t=%0t: got rdy,vld,res,zyk=%h required %h", i, $time, got_vec(i), exp_vec(i));
        end
      end
    end
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  function automatic bit busy();
    for (int i = 0; i < NI; i++) if (m_rem[i] > 0) return 1'b1;
    return (rdy != {NI{1'b1}});
  endfunction

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy() && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", 64'(busy()), 64'd0);
  endtask

  task automatic run_job(input logic [15:0] a, input logic [15:0] b);
    start_i = 1'b1;
    Zahl1_i = a;
    Zahl2_i = b;
    @(negedge clk);
    start_i = 1'b0;
    wait_idle(3000);
  endtask

  int          cyc, g;
  logic [15:0] ra, rb;

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; Zahl1_i = '0; Zahl2_i = '0;

    check("ref_e_12_8_n", 64'(steps_ref(0, 12, 8)), 3);
    check("ref_s_12_8_n", 64'(steps_ref(1, 12, 8)), 5);
    check("ref_e_48_18_n", 64'(steps_ref(0, 48, 18)), 5);
    check("ref_s_48_18_n", 64'(steps_ref(1, 48, 18)), 6);
    check("ref_e_1000_1_n", 64'(steps_ref(0, 1000, 1)), 1000);
    check("ref_gcd_48_18", gcd_ref(48, 18), 6);
    check("ref_gcd_0_35", gcd_ref(0, 35), 35);

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", 64'(rdy), 64'h1F);
    check("rst_valid", 64'(vld), 64'h0);
    check("rst_res", 64'(r0), 0);
    rst = 1'b0;

    run_job(16'd12, 16'd8);
    check("e_12_8_res", 64'(r0), 4);
    check("e_12_8_zyk", 64'(z0), 3);
    check("s_12_8_res", 64'(r1), 4);
    check("s_12_8_zyk", 64'(z1), 5);
    run_job(16'd48, 16'd18);
    check("e_48_18_res", 64'(r0), 6);
    check("e_48_18_zyk", 64'(z0), 5);
    check("s_48_18_res", 64'(r1), 6);
    check("s_48_18_zyk", 64'(z1), 6);
    run_job(16'd0, 16'd0);
    check("e_0_0_res", 64'(r0), 0);
    check("e_0_0_zyk", 64'(z0), 1);
    check("s_0_0_zyk", 64'(z1), 1);
    run_job(16'd0, 16'd35);
    check("e_0_35_res", 64'(r0), 35);
    check("s_0_35_res", 64'(r1), 35);
    run_job(16'hFFFF, 16'hFFFF);
    check("e_max_res", 64'(r0), 65535);
    check("s_max_zyk", 64'(z1), 1);

    // Stein only: Euclid variants would need 65535 cycles, so they are aborted afterwards.
    start_i = 1'b1; Zahl1_i = 16'hFFFF; Zahl2_i = 16'd1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (!vld[1] && cyc < 300) begin @(negedge clk); cyc++; end
    check("s_ffff_1_res", 64'(r1), 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    wait_idle(100);

    start_i = 1'b1; Zahl1_i = 16'd1000; Zahl2_i = 16'd1;
    cyc = 0;
    @(negedge clk);
    start_i = 1'b0;
    while (!vld[2] && cyc < 2000) begin cyc++; @(negedge clk); end
    check("sat_latency", 64'(cyc), 1000);
    check("sat_zyk", 64'(z2), 255);
    check("sat_res", 64'(r2), 1);
    check("e_1000_1_zyk", 64'(z0), 1000);
    wait_idle(3000);

    // start held through RUN with changing operands; finishing units restart back-to-back.
    start_i = 1'b1; Zahl1_i = 16'd12; Zahl2_i = 16'd8;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      Zahl1_i = 16'($urandom_range(0, 255));
      Zahl2_i = 16'($urandom_range(0, 255));
    end
    start_i = 1'b0;
    wait_idle(3000);

    start_i = 1'b1; Zahl1_i = 16'd1000; Zahl2_i = 16'd1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_valid", 64'(vld), 0);
    check("abort_ready", 64'(rdy), 64'h1F);

    abort_i = 1'b1; start_i = 1'b1; Zahl1_i = 16'd5; Zahl2_i = 16'd5;
    @(negedge clk);
    abort_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    check("abort_start_ready", 64'(rdy), 64'h1F);
    check("abort_start_valid", 64'(vld), 0);

    start_i = 1'b1; Zahl1_i = 16'd1000; Zahl2_i = 16'd1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_res", 64'(r0), 0);
    check("midrst_zyk", 64'(z0), 0);
    check("midrst_ready", 64'(rdy), 64'h1F);
    run_job(16'd21, 16'd14);
    check("e_21_14_res", 64'(r0), 7);
    check("s_21_14_res", 64'(r1), 7);

    for (int j = 0; j < 150; j++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          ra = 16'($urandom_range(0, 200));
          rb = 16'($urandom_range(0, 200));
        end
        2: begin
          g  = $urandom_range(1, 3000);
          ra = 16'(g * $urandom_range(0, 20));
          rb = 16'(g * $urandom_range(1, 20));
        end
        default: begin
          ra = 16'($urandom_range(0, 255));
          rb = 16'd0;
        end
      endcase
      start_i = 1'b1; Zahl1_i = ra; Zahl2_i = rb;
      repeat ($urandom_range(1, 3)) begin
        @(negedge clk);
        Zahl1_i = 16'($urandom_range(0, 255));
        Zahl2_i = 16'($urandom_range(0, 255));
      end
      start_i = 1'b0;
      cyc = 0;
      while (busy() && cyc < 3000) begin
        abort_i = ($urandom_range(0, 199) == 0);
        @(negedge clk);
        cyc++;
      end
      abort_i = 1'b0;
      wait_idle(3000);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ggt_param_core.md
# ggt_param_core

Parametrised greatest-common-divisor (ggT) engine: next generation of the fixed 16-bit ggT unit. It provides configurable operand width, a build-time choice between subtractive Euclid and binary (Stein) algorithm, and a ready/valid handshake with abort. It also reports the iteration count for performance comparison between the two algorithms. It sits behind the same file-driven testbench flow and produces one result per accepted start.

## Interface

- WIDTH, 16, operand and result width in bits (≥2)
- MODE, 0, algorithm select: 0 = subtractive Euclid, 1 = binary Stein
- CNT_W, 16, width of iteration counter zyklen_o (saturating)

- clk  in  1  rising-edge clock, sole clock domain
- rst  in  1  synchronous, active-high reset
- start_i  in  1  request; accepted only when ready_o=1
- abort_i  in  1  synchronous cancel of current job
- Zahl1_i  in  WIDTH  operand A, sampled on accepted start
- Zahl2_i  in  WIDTH  operand B, sampled on accepted start
- ready_o  out  1  1 in IDLE and DONE (state != RUN)
- ergebnis  out  WIDTH  ggT result, stable while valid=1
- valid  out  1  level, high in DONE until next accepted start or abort
- zyklen_o  out  CNT_W  number of RUN cycles of the last job, saturates at all-ones

## Operation

- States: IDLE, RUN, DONE. Reset → IDLE; outputs after reset: ready_o=1, valid=0, ergebnis=0, zyklen_o=0.
- Priority each edge: rst > abort_i > start_i.
- IDLE/DONE + start_i (no abort): load a=Zahl1_i, b=Zahl2_i, k=0, cnt=0, valid←0 → RUN.
- RUN: start_i ignored. abort_i → IDLE, valid stays 0, ergebnis/zyklen_o keep previous values.
- DONE + abort_i → IDLE, valid←0. IDLE + abort_i → no effect. IDLE/DONE with abort_i and start_i together: abort wins, start dropped.
- Every RUN cycle increments cnt (saturating at 2^CNT_W−1), including the terminating cycle. On termination: ergebnis←result, zyklen_o←cnt+1 (saturated), → DONE.
- MODE=0, per RUN cycle, first match:
  - a==0 → result b
  - b==0 → result a
  - a==b → result a
  - a>b → a←a−b
  - else → b←b−a
- MODE=1, per RUN cycle, first match:
  - a==0 → result b<<k
  - b==0 → result a<<k
  - a==b → result a<<k
  - both even → a←a>>1, b←b>>1, k←k+1
  - a even → a←a>>1
  - b even → b←b>>1
  - both odd → larger←(larger−smaller)>>1
- k width: clog2(WIDTH)+1. Result shift cannot overflow (ggT ≤ nonzero operand). ggT(0,0)=0.
- All arithmetic unsigned, WIDTH bits; subtraction only of smaller from larger, no wrap.

## Timing

- Start accepted at edge E0: ready_o=0 from E0. Job terminating in n RUN cycles sets valid=1, ready_o=1 and ergebnis at edge E0+n.
- Minimum latency n=1 (zero operand or equal operands).
- Back-to-back: start_i high in the first DONE cycle is accepted; valid drops at that edge.
- Reset mid-RUN: next edge IDLE, all outputs at reset values.
- Euclid worst case n = max(A,B) cycles (e.g. (X,1)); Stein worst case ≤ 2·WIDTH+1 cycles.

## Test plan

- MODE=0, WIDTH=16: (12,8) → valid after 3 cycles, ergebnis=4, zyklen_o=3; (48,18) → ergebnis=6, zyklen_o=5.
- MODE=1, WIDTH=16: (12,8) → ergebnis=4, zyklen_o=5; (48,18) → ergebnis=6, zyklen_o=6.
- Both modes, boundary operands: (0,0) → 0 with zyklen_o=1; (0,35) → 35; (65535,65535) → 65535 with zyklen_o=1; MODE=1 (65535,1) → 1.
- MODE=0, WIDTH=16, CNT_W=8: (1000,1) → ergebnis=1, zyklen_o=255 (saturated), valid exactly 1000 cycles after start.
- Handshake: start_i held high during RUN → ignored, inputs changed mid-RUN do not affect result. abort_i at 2nd RUN cycle of (1000,1) → IDLE next edge, valid never rises. abort_i+start_i together in IDLE → stays IDLE.
- rst asserted mid-RUN, then (21,14) started → first job discarded, all outputs 0 after reset, second job ergebnis=7. Compare file-driven pairs against the reference ggT model for WIDTH=8 and 16.
